// File: rtl/punc_dump_pkg.sv
// Shared tags, state encoding and tail-state helper for the PUnC debug dumper.
// PUNC_DUMP_CHECKSUM_EN adds the CSUM state after the memory window.
package punc_dump_pkg;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_RF   = 2'd0;
    localparam tag_t TAG_PC   = 2'd1;
    localparam tag_t TAG_MEM  = 2'd2;
    localparam tag_t TAG_CSUM = 2'd3;

`ifdef PUNC_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RF   = 3'd1,
        ST_PC   = 3'd2,
        ST_MEM  = 3'd3,
`ifdef PUNC_DUMP_CHECKSUM_EN
        ST_CSUM = 3'd4,
`endif
        ST_DONE = 3'd5
    } dump_state_e;

    // State entered once the last PC/MEM word has been accepted.
    function automatic dump_state_e tail_state();
`ifdef PUNC_DUMP_CHECKSUM_EN
        return ST_CSUM;
`else
        return ST_DONE;
`endif
    endfunction

endpackage

// File: rtl/punc_dump_obuf.sv
// Valid/ready output holding register for the PUnC debug dumper.
// Loads one word, holds it stable until accepted, clears on handshake or rst.
module punc_dump_obuf
    import punc_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  tag_t        tag_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_i,
    input  logic        ready_i,
    output logic        valid_o,
    output tag_t        tag_o,
    output logic [15:0] addr_o,
    output logic [15:0] data_o
);

    logic        valid_q;
    tag_t        tag_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= TAG_RF;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= tag_i;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            tag_q   <= TAG_RF;
            addr_q  <= '0;
            data_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/punc_debug_dumper.sv
// Post-run dumper: streams R0-R7, PC and a memory window as tagged words.
// Define PUNC_DUMP_CHECKSUM_EN to append a wrapping 16-bit checksum word.
module punc_debug_dumper
    import punc_dump_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int MAX_CNT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        mem_base,
    input  logic [MAX_CNT-1:0] mem_count,
    output logic [2:0]         rf_debug_addr,
    output logic [15:0]        mem_debug_addr,
    input  logic [15:0]        rf_debug_data,
    input  logic [15:0]        pc_debug_data,
    input  logic [15:0]        mem_debug_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_tag,
    output logic [15:0]        out_addr,
    output logic [15:0]        out_data,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] LAT = 2'(RD_LAT);

    dump_state_e        state_q;
    logic [2:0]         rf_addr_q;
    logic [15:0]        mem_addr_q;
    logic [15:0]        base_q;
    logic [MAX_CNT-1:0] mcnt_q;
    logic [1:0]         wcnt_q;
    logic               wt_q;
    logic               busy_q;
    logic               done_q;

    logic        hs;
    logic        ld;
    tag_t        ld_tag;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;

`ifdef PUNC_DUMP_CHECKSUM_EN
    logic [15:0] sum_q;
`endif

    assign hs = out_valid && out_ready;
    // Sample once the issued address has settled for RD_LAT cycles.
    assign ld = wt_q && (wcnt_q == 2'd0);

    always_comb begin
        ld_tag  = TAG_RF;
        ld_addr = '0;
        ld_data = '0;
        case (state_q)
            ST_RF: begin
                ld_tag  = TAG_RF;
                ld_addr = {13'd0, rf_addr_q};
                ld_data = rf_debug_data;
            end
            ST_PC: begin
                ld_tag  = TAG_PC;
                ld_data = pc_debug_data;
            end
            ST_MEM: begin
                ld_tag  = TAG_MEM;
                ld_addr = mem_addr_q;
                ld_data = mem_debug_data;
            end
`ifdef PUNC_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                ld_tag  = TAG_CSUM;
                ld_data = sum_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rf_addr_q  <= '0;
            mem_addr_q <= '0;
            base_q     <= '0;
            mcnt_q     <= '0;
            wcnt_q     <= '0;
            wt_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wt_q) begin
                if (wcnt_q == 2'd0) wt_q <= 1'b0;
                else                wcnt_q <= wcnt_q - 2'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RF;
                        rf_addr_q <= '0;
                        base_q    <= mem_base;
                        mcnt_q    <= mem_count;
                        wt_q      <= 1'b1;
                        wcnt_q    <= LAT;
                        busy_q    <= 1'b1;
                    end
                end
                ST_RF: begin
                    if (hs) begin
                        wt_q   <= 1'b1;
                        wcnt_q <= LAT;
                        if (rf_addr_q == 3'd7) state_q <= ST_PC;
                        else rf_addr_q <= rf_addr_q + 3'd1;
                    end
                end
                ST_PC: begin
                    if (hs) begin
                        wcnt_q <= LAT;
                        if (mcnt_q != '0) begin
                            state_q    <= ST_MEM;
                            mem_addr_q <= base_q;
                            wt_q       <= 1'b1;
                        end else begin
                            state_q <= tail_state();
                            wt_q    <= CSUM_EN;
                            busy_q  <= CSUM_EN;
                            done_q  <= !CSUM_EN;
                        end
                    end
                end
                ST_MEM: begin
                    if (hs) begin
                        wcnt_q <= LAT;
                        if (mcnt_q == MAX_CNT'(1)) begin
                            state_q <= tail_state();
                            wt_q    <= CSUM_EN;
                            busy_q  <= CSUM_EN;
                            done_q  <= !CSUM_EN;
                        end else begin
                            mcnt_q     <= mcnt_q - MAX_CNT'(1);
                            mem_addr_q <= mem_addr_q + 16'd1;
                            wt_q       <= 1'b1;
                        end
                    end
                end
`ifdef PUNC_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (hs) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PUNC_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            sum_q <= '0;
        end else if (ld && state_q != ST_CSUM) begin
            sum_q <= sum_q + ld_data;
        end
    end
`endif

    punc_dump_obuf u_obuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ld),
        .tag_i   (ld_tag),
        .addr_i  (ld_addr),
        .data_i  (ld_data),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .tag_o   (out_tag),
        .addr_o  (out_addr),
        .data_o  (out_data)
    );

    assign rf_debug_addr  = rf_addr_q;
    assign mem_debug_addr = mem_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Scoreboard bench for punc_debug_dumper with a registered-read core model.
// Honours PUNC_DUMP_CHECKSUM_EN when expecting the trailing checksum word.
module tb_punc_debug_dumper;
    import punc_dump_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mem_base;
    logic [15:0] mem_count;
    logic [2:0]  rf_debug_addr;
    logic [15:0] mem_debug_addr;
    logic [15:0] rf_debug_data;
    logic [15:0] pc_debug_data;
    logic [15:0] mem_debug_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_tag;
    logic [15:0] out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    punc_debug_dumper #(.RD_LAT(1), .MAX_CNT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mem_base       (mem_base),
        .mem_count      (mem_count),
        .rf_debug_addr  (rf_debug_addr),
        .mem_debug_addr (mem_debug_addr),
        .rf_debug_data  (rf_debug_data),
        .pc_debug_data  (pc_debug_data),
        .mem_debug_data (mem_debug_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tag        (out_tag),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: one-cycle registered debug reads.
    logic [15:0] rf_m [8];
    logic [15:0] pc_m;
    logic [15:0] mem_m [65536];

    always @(posedge clk) begin
        rf_debug_data  <= rf_m[rf_debug_addr];
        mem_debug_data <= mem_m[mem_debug_addr];
    end
    assign pc_debug_data = pc_m;

    typedef struct packed {
        logic [1:0]  tag;
        logic [15:0] addr;
        logic [15:0] data;
    } word_t;

    word_t       sb[$];
    word_t       w_exp;
    word_t       prev;
    logic        hold_p;
    int          pass_cnt;
    int          tot_cnt;
    int          acc_cnt;
    logic [1:0]  last_tag;
    logic [15:0] exp_sum;

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic push(input logic [1:0] t, input logic [15:0] a,
                        input logic [15:0] d);
        word_t w;
        w.tag  = t;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
        if (t != TAG_CSUM) exp_sum = exp_sum + d;
    endtask

    task automatic push_dump(input logic [15:0] base, input int cnt);
        logic [15:0] a;
        exp_sum = '0;
        for (int i = 0; i < 8; i++) push(TAG_RF, 16'(i), rf_m[i]);
        push(TAG_PC, 16'h0000, pc_m);
        for (int j = 0; j < cnt; j++) begin
            a = base + 16'(j);
            push(TAG_MEM, a, mem_m[a]);
        end
`ifdef PUNC_DUMP_CHECKSUM_EN
        push(TAG_CSUM, 16'h0000, exp_sum);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] c);
        mem_base  = b;
        mem_count = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 500) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, 48'(done), 48'd1);
        chk({nm, "_busy_at_done"}, 48'(busy), 48'd0);
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p)
                chk("hold_stable", {13'd0, out_valid, out_tag, out_addr, out_data},
                    {13'd0, 1'b1, prev});
            if (out_valid && out_ready) begin
                chk("sb_has_word", 48'(sb.size() != 0), 48'd1);
                if (sb.size() != 0) begin
                    w_exp = sb.pop_front();
                    chk("word", {14'd0, out_tag, out_addr, out_data}, {14'd0, w_exp});
                end
                acc_cnt++;
                last_tag = out_tag;
            end
            hold_p = out_valid && !out_ready;
            prev   = {out_tag, out_addr, out_data};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acc0;
        pass_cnt  = 0;
        tot_cnt   = 0;
        acc_cnt   = 0;
        hold_p    = 1'b0;
        last_tag  = TAG_RF;
        exp_sum   = '0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        mem_base  = '0;
        mem_count = '0;
        for (int i = 0; i < 8; i++) rf_m[i] = 16'h1000 + 16'(i);
        pc_m = 16'h3005;
        mem_m[16'h0000] = 16'h3333;
        mem_m[16'h3000] = 16'hAAAA;
        mem_m[16'h3001] = 16'hBBBB;
        mem_m[16'h3002] = 16'hCCCC;
        mem_m[16'h3003] = 16'hDDDD;
        mem_m[16'hFFFE] = 16'h1111;
        mem_m[16'hFFFF] = 16'h2222;

        tick();
        tick();
        chk("rst_valid", 48'(out_valid), 48'd0);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_done", 48'(done), 48'd0);
        chk("rst_rfaddr", 48'(rf_debug_addr), 48'd0);
        chk("rst_memaddr", 48'(mem_debug_addr), 48'd0);
        chk("rst_tag", 48'(out_tag), 48'd0);
        chk("rst_data", 48'(out_data), 48'd0);
        rst = 1'b0;
        tick();

        // RF + PC only, with start-to-valid latency.
        push_dump(16'h0000, 0);
        mem_base  = 16'h0000;
        mem_count = 16'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_busy", 48'(busy), 48'd1);
        chk("lat_rfaddr0", 48'(rf_debug_addr), 48'd0);
        chk("lat_valid_n0", 48'(out_valid), 48'd0);
        tick();
        chk("lat_valid_n1", 48'(out_valid), 48'd0);
        tick();
        chk("lat_valid_n2", 48'(out_valid), 48'd1);
        wait_done("t1");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_done_one_cycle", 48'(done), 48'd0);
        chk("t1_start_at_done_ignored", 48'(busy), 48'd0);
        tick();
        tick();
        tick();
        chk("t1_still_idle", 48'(busy), 48'd0);
        chk("t1_no_word", 48'(out_valid), 48'd0);
        chk("t1_sb_empty", 48'(sb.size()), 48'd0);
        chk("t1_word_cnt", 48'(acc_cnt), 48'(9 + (CSUM_EN ? 1 : 0)));

        // Memory window.
        push_dump(16'h3000, 4);
        pulse_start(16'h3000, 16'd4);
        wait_done("t2");
        tick();
        chk("t2_sb_empty", 48'(sb.size()), 48'd0);

        // Address wrap at 0xFFFF.
        push_dump(16'hFFFE, 3);
        pulse_start(16'hFFFE, 16'd3);
        wait_done("t3");
        tick();
        chk("t3_sb_empty", 48'(sb.size()), 48'd0);
        chk("t3_memaddr_hold", 48'(mem_debug_addr), 48'h0000);

        // Backpressure mid-RF plus a start while busy.
        push_dump(16'h3000, 4);
        acc0 = acc_cnt;
        pulse_start(16'h3000, 16'd4);
        n = 0;
        while (acc_cnt < acc0 + 3 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_reach_rf3", 48'(acc_cnt - acc0), 48'd3);
        out_ready = 1'b0;
        mem_base  = 16'h1234;
        mem_count = 16'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t4_stall_valid", 48'(out_valid), 48'd1);
        chk("t4_stall_no_accept", 48'(acc_cnt - acc0), 48'd3);
        out_ready = 1'b1;
        wait_done("t4");
        tick();
        chk("t4_total", 48'(acc_cnt - acc0), 48'(13 + (CSUM_EN ? 1 : 0)));
        chk("t4_sb_empty", 48'(sb.size()), 48'd0);

        // Reset during MEM, then a fresh dump.
        push_dump(16'h3000, 4);
        last_tag = TAG_RF;
        pulse_start(16'h3000, 16'd4);
        n = 0;
        while (last_tag != TAG_MEM && n < 200) begin
            tick();
            n++;
        end
        chk("t5_in_mem", 48'(last_tag), 48'(TAG_MEM));
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 48'(out_valid), 48'd0);
        chk("t5_rst_busy", 48'(busy), 48'd0);
        chk("t5_rst_memaddr", 48'(mem_debug_addr), 48'd0);
        chk("t5_rst_rfaddr", 48'(rf_debug_addr), 48'd0);
        chk("t5_rst_data", 48'(out_data), 48'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        push_dump(16'h0000, 0);
        pulse_start(16'h0000, 16'd0);
        wait_done("t5");
        tick();
        chk("t5_sb_empty", 48'(sb.size()), 48'd0);

        // Small values: checksum build expects a final 0x000A word.
        for (int i = 0; i < 8; i++) rf_m[i] = 16'h0001;
        pc_m = 16'h0002;
        exp_sum = '0;
        for (int i = 0; i < 8; i++) push(TAG_RF, 16'(i), 16'h0001);
        push(TAG_PC, 16'h0000, 16'h0002);
`ifdef PUNC_DUMP_CHECKSUM_EN
        push(TAG_CSUM, 16'h0000, 16'h000A);
`endif
        pulse_start(16'h0000, 16'd0);
        wait_done("t6");
        tick();
        chk("t6_sb_empty", 48'(sb.size()), 48'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
